// File: rtl/keyctrl_pkg.sv
// keyctrl_pkg: shared scancodes, decode FSM states and key_held bit indices for pong_key_decoder.
package keyctrl_pkg;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_e;
  localparam int KH_W     = 0;
  localparam int KH_S     = 1;
  localparam int KH_UP    = 2;
  localparam int KH_DOWN  = 3;
  localparam int KH_SPACE = 4;
endpackage

// File: rtl/keycode_sync.sv
// keycode_sync: synchronises the rolling scancode word, waits for it to hold steady and emits each newly accepted byte.
// Ports: clk, rst (sync active-high), keycode_in[31:0] (async), acc_byte[7:0] (newest byte of accepted word), acc_strobe (one-cycle pulse per decoded byte).
module keycode_sync #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] keycode_in,
  output logic [7:0]  acc_byte,
  output logic        acc_strobe
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  logic [31:0] meta_q, s_q, last_word_q, last_word_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic primed_q, primed_d, accept;
  logic [7:0] byte_q, byte_d;
  logic strobe_q, strobe_d;
  // meta_q is the value s takes next edge, so comparing it with s_q tracks "s equals previous s" one cycle early
  always_comb begin
    stab_cnt_d = (meta_q != s_q) ? '0 : (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 1'b1;
    accept = (stab_cnt_q != STAB_MAX) && (stab_cnt_d == STAB_MAX) && (s_q != last_word_q);
    last_word_d = accept ? s_q : last_word_q;
    primed_d = primed_q | accept;
    strobe_d = accept & primed_q;
    byte_d = accept ? s_q[7:0] : byte_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      s_q <= '0;
      stab_cnt_q <= '0;
      last_word_q <= '0;
      primed_q <= 1'b0;
      byte_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      meta_q <= keycode_in;
      s_q <= meta_q;
      stab_cnt_q <= stab_cnt_d;
      last_word_q <= last_word_d;
      primed_q <= primed_d;
      byte_q <= byte_d;
      strobe_q <= strobe_d;
    end
  end
  assign acc_byte = byte_q;
  assign acc_strobe = strobe_q;
endmodule

// File: rtl/pong_key_decoder.sv
// pong_key_decoder: turns the PS/2 rolling scancode word into held-key flags and resolved Pong paddle/serve commands.
// Ports: clk, rst (sync active-high), keycode_in[31:0] (async rolling word, [7:0] newest); outputs left_up, left_down,
// right_up, right_down, serve (pulse), byte_strobe (pulse per decoded byte), key_held[4:0] = {space, down, up, s, w}.
// Build option KEYCTRL_LAST_WINS_EN: when both keys of a pair are held the most recently made one drives; otherwise neutral.
module pong_key_decoder
  import keyctrl_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] keycode_in,
  output logic        left_up,
  output logic        left_down,
  output logic        right_up,
  output logic        right_down,
  output logic        serve,
  output logic        byte_strobe,
  output logic [4:0]  key_held
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [7:0] rx_byte;
  logic rx_strobe;
  keycode_sync #(.STABLE_CYCLES(STABLE_CYCLES)) u_sync (
    .clk(clk),
    .rst(rst),
    .keycode_in(keycode_in),
    .acc_byte(rx_byte),
    .acc_strobe(rx_strobe)
  );
  state_e state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [4:0] held_q, held_d, hit;
  logic ext, brk, make;
  logic left_up_q, left_up_d, left_down_q, left_down_d;
  logic right_up_q, right_up_d, right_down_q, right_down_d;
  logic serve_q, serve_d, byte_strobe_q;
  // hit marks the held flag addressed by a non-prefix byte; prefixes never match a key code so need no extra gating
  always_comb begin
    ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    hit = '0;
    hit[KH_W] = rx_strobe && !ext && rx_byte == SC_W;
    hit[KH_S] = rx_strobe && !ext && rx_byte == SC_S;
    hit[KH_SPACE] = rx_strobe && !ext && rx_byte == SC_SPACE;
    hit[KH_UP] = rx_strobe && ext && rx_byte == SC_UP;
    hit[KH_DOWN] = rx_strobe && ext && rx_byte == SC_DOWN;
    make = rx_strobe && !brk;
    held_d = brk ? (held_q & ~hit) : (held_q | hit);
    serve_d = make && hit[KH_SPACE] && !held_q[KH_SPACE];
    state_d = !rx_strobe ? ((state_q != ST_IDLE && tmo_cnt_q == TMO_LAST) ? ST_IDLE : state_q)
            : (rx_byte == SC_EXT) ? (brk ? ST_EXT_BRK : ST_EXT)
            : (rx_byte == SC_BRK) ? (ext ? ST_EXT_BRK : ST_BRK)
            : ST_IDLE;
    tmo_cnt_d = (rx_strobe || state_d == ST_IDLE) ? '0 : tmo_cnt_q + 1'b1;
  end
`ifdef KEYCTRL_LAST_WINS_EN
  logic last_s_q, last_s_d, last_down_q, last_down_d;
  // last_*_q = 1 when the down-direction key of the pair was made most recently
  always_comb begin
    last_s_d = (make && hit[KH_S]) ? 1'b1 : (make && hit[KH_W]) ? 1'b0 : last_s_q;
    last_down_d = (make && hit[KH_DOWN]) ? 1'b1 : (make && hit[KH_UP]) ? 1'b0 : last_down_q;
    left_up_d = held_d[KH_W] & (~held_d[KH_S] | ~last_s_d);
    left_down_d = held_d[KH_S] & (~held_d[KH_W] | last_s_d);
    right_up_d = held_d[KH_UP] & (~held_d[KH_DOWN] | ~last_down_d);
    right_down_d = held_d[KH_DOWN] & (~held_d[KH_UP] | last_down_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_s_q <= 1'b0;
      last_down_q <= 1'b0;
    end else begin
      last_s_q <= last_s_d;
      last_down_q <= last_down_d;
    end
  end
`else
  always_comb begin
    left_up_d = held_d[KH_W] & ~held_d[KH_S];
    left_down_d = held_d[KH_S] & ~held_d[KH_W];
    right_up_d = held_d[KH_UP] & ~held_d[KH_DOWN];
    right_down_d = held_d[KH_DOWN] & ~held_d[KH_UP];
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmo_cnt_q <= '0;
      held_q <= '0;
      left_up_q <= 1'b0;
      left_down_q <= 1'b0;
      right_up_q <= 1'b0;
      right_down_q <= 1'b0;
      serve_q <= 1'b0;
      byte_strobe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      held_q <= held_d;
      left_up_q <= left_up_d;
      left_down_q <= left_down_d;
      right_up_q <= right_up_d;
      right_down_q <= right_down_d;
      serve_q <= serve_d;
      byte_strobe_q <= rx_strobe;
    end
  end
  assign left_up = left_up_q;
  assign left_down = left_down_q;
  assign right_up = right_up_q;
  assign right_down = right_down_q;
  assign serve = serve_q;
  assign byte_strobe = byte_strobe_q;
  assign key_held = held_q;
endmodule

// File: tb/tb_pong_key_decoder.sv
// tb_pong_key_decoder: randomized and directed byte streams checked against a prefix-flag model of the key decoder.
module tb_pong_key_decoder;
  localparam int STB = 4;
  localparam int TMO = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] keycode_in = '0;
  logic left_up, left_down, right_up, right_down, serve, byte_strobe;
  logic [4:0] key_held;
  pong_key_decoder #(.STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .keycode_in(keycode_in),
    .left_up(left_up),
    .left_down(left_down),
    .right_up(right_up),
    .right_down(right_down),
    .serve(serve),
    .byte_strobe(byte_strobe),
    .key_held(key_held)
  );
  always #5 clk = ~clk;
  wire [9:0] outs = {left_up, left_down, right_up, right_down, serve, key_held};
  int checks = 0;
  int failures = 0;
  logic [31:0] cur = '0;
  bit m_ext, m_brk, m_serve, lw_l, lw_r;
  bit [4:0] m_held;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [1:0] pair(bit a, bit b, bit lw);
    if (a && b) begin
`ifdef KEYCTRL_LAST_WINS_EN
      return lw ? 2'b01 : 2'b10;
`else
      return 2'b00;
`endif
    end
    return {a, b};
  endfunction
  function automatic logic [9:0] exp_out();
    return {pair(m_held[0], m_held[1], lw_l), pair(m_held[2], m_held[3], lw_r), m_serve, m_held};
  endfunction
  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_serve = 0; lw_l = 0; lw_r = 0; m_held = '0;
  endtask
  // prefixes accumulate as flags; any other byte consumes them
  task automatic model_byte(input logic [7:0] b);
    int k;
    m_serve = 0;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = -1;
      if (!m_ext && b == 8'h1D) k = 0;
      if (!m_ext && b == 8'h1B) k = 1;
      if (m_ext && b == 8'h75) k = 2;
      if (m_ext && b == 8'h72) k = 3;
      if (!m_ext && b == 8'h29) k = 4;
      if (k >= 0) begin
        if (!m_brk && k == 4 && !m_held[4]) m_serve = 1;
        m_held[k] = !m_brk;
        if (!m_brk && k < 2) lw_l = (k == 1);
        if (!m_brk && (k == 2 || k == 3)) lw_r = (k == 3);
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n;
    @(posedge clk);
    #1 keycode_in = {cur[23:0], b};
    cur = keycode_in;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1 n++;
      if (byte_strobe) break;
    end
    model_byte(b);
    check("latency", n, STB + 3);
    check("outs", outs, exp_out());
    @(posedge clk);
    #1 check("pulse_end", {byte_strobe, serve}, 0);
    m_serve = 0;
  endtask
  task automatic quiet(input int cycles, input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 cnt += int'(byte_strobe);
    end
    check(tag, cnt, 0);
  endtask
  logic [7:0] dir_bytes[] = '{8'h1D, 8'hF0, 8'h1D, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h75,
                              8'h1D, 8'h1B, 8'hF0, 8'h1B, 8'hF0, 8'h1D, 8'hE0, 8'h72, 8'hE0,
                              8'h75, 8'hE0, 8'hF0, 8'h72, 8'hE0, 8'hF0, 8'h75, 8'h72};
  logic [7:0] tbl[8] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h29, 8'h75, 8'h72, 8'h00};
  initial begin
    int n_st, n_sv;
    bit exp_sv;
    logic [7:0] b;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_outs", outs, 0);
    check("rst_strobe", byte_strobe, 0);
    @(posedge clk);
    #1 keycode_in = 32'h0000_001D;
    cur = keycode_in;
    quiet(15, "prime_strobes");
    check("prime_outs", outs, 0);
    foreach (dir_bytes[i]) send(dir_bytes[i]);
    send(8'hE0);
    repeat (TMO + 20) @(posedge clk);
    m_ext = 0;
    m_brk = 0;
    send(8'h75);
    check("tmo_right_up", right_up, 0);
    send(8'hE0);
    repeat (TMO - 40) @(posedge clk);
    send(8'h75);
    check("pre_tmo_right_up", right_up, 1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    n_st = 0;
    n_sv = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 20 && i % 2 == 0) keycode_in = cur ^ {8'(i + 1), 24'h0};
      if (i == 20) keycode_in = {cur[23:0], 8'h29};
      @(posedge clk);
      #1 n_st += int'(byte_strobe);
      n_sv += int'(serve);
    end
    cur = {cur[23:0], 8'h29};
    model_byte(8'h29);
    exp_sv = m_serve;
    m_serve = 0;
    check("glitch_strobes", n_st, 1);
    check("glitch_serves", n_sv, int'(exp_sv));
    check("glitch_outs", outs, exp_out());
    send(8'h29);
    send(8'hF0);
    send(8'h29);
    for (int i = 0; i < 150; i++) begin
      tbl[7] = 8'($urandom);
      b = tbl[$urandom_range(0, 7)];
      if ({cur[23:0], b} == cur) b = 8'h11;
      send(b);
    end
    send(8'h11);
    send(8'h1D);
    send(8'hE0);
    send(8'hF0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check("rst_mid_outs", outs, 0);
    check("rst_mid_strobe", byte_strobe, 0);
    rst = 1'b0;
    model_reset();
    quiet(15, "reprime_strobes");
    check("reprime_outs", outs, 0);
    send(8'h1D);
    check("post_rst_left_up", left_up, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
